// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end for the 1101 sequence detector: valid/ready word input,
// one-word holding buffer, gapless one-bit-per-clock output on ser_bit.
//
// state | meaning
// IDLE  | nothing shifting; ser_bit parked at IDLE_BIT
// SHIFT | a word is being emitted, bit_cnt = index of the bit on ser_bit
module seq_bit_serializer #(
  parameter int   DATA_W    = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ser_bit,
  output logic              bit_valid,
  output logic              frame_start,
  output logic              busy
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state, state_next;
  logic [CW-1:0]     bit_cnt, cnt_next;
  logic [DATA_W-1:0] shift_q, hold_q, in_ord;
  logic              hold_full, hold_next, ready_next;
  logic              accept, last_bit, load_hold, load_in, write_hold;

  // Words are stored pre-ordered so the next outgoing bit is always the MSB.
  function automatic logic [DATA_W-1:0] order_bits(input logic [DATA_W-1:0] w);
    logic [DATA_W-1:0] r;
    r = w;
    if (!MSB_FIRST) begin
      for (int i = 0; i < DATA_W; i++) r[i] = w[DATA_W-1-i];
    end
    return r;
  endfunction

  always_comb begin
    in_ord     = order_bits(in_data);
    accept     = in_valid && in_ready;
    last_bit   = (state == SHIFT) && (bit_cnt == LAST);
    load_hold  = last_bit && hold_full;
    load_in    = accept && ((state == IDLE) || (last_bit && !hold_full));
    write_hold = accept && !load_in;
    hold_next  = write_hold || (hold_full && !load_hold);
    state_next = state;
    if (load_hold || load_in) state_next = SHIFT;
    else if (last_bit)        state_next = IDLE;
    cnt_next = '0;
    if (!(load_hold || load_in) && (state == SHIFT) && !last_bit) cnt_next = bit_cnt + 1'b1;
    // Ready also in the last-bit cycle of a word, since hold drains at that edge.
    ready_next = !hold_next || ((state_next == SHIFT) && (cnt_next == LAST));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full   <= 1'b0;
      in_ready    <= 1'b0;
      ser_bit     <= IDLE_BIT;
      bit_valid   <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_next;
      bit_cnt     <= cnt_next;
      hold_full   <= hold_next;
      in_ready    <= ready_next;
      bit_valid   <= (state_next == SHIFT);
      frame_start <= load_hold || load_in;
      busy        <= (state_next == SHIFT) || hold_next;
      if (write_hold) hold_q <= in_ord;
      if (load_hold) begin
        ser_bit <= hold_q[DATA_W-1];
        shift_q <= hold_q << 1;
      end else if (load_in) begin
        ser_bit <= in_ord[DATA_W-1];
        shift_q <= in_ord << 1;
      end else if ((state == SHIFT) && !last_bit) begin
        ser_bit <= shift_q[DATA_W-1];
        shift_q <= shift_q << 1;
      end else begin
        ser_bit <= IDLE_BIT;
      end
    end
  end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Bench for seq_bit_serializer: MSB-first and LSB-first instances driven in parallel,
// checked every cycle against a word-queue reference model.
module tb_seq_bit_serializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       rdy_m, ser_m, bv_m, fs_m, busy_m;
  logic       rdy_l, ser_l, bv_l, fs_l, busy_l;

  int checks = 0;
  int passes = 0;

  logic       m_cur = 1'b0;
  logic [7:0] m_word = '0;
  int         m_pos = 0;
  logic [7:0] m_hold[$];
  logic       m_ready = 1'b0;
  logic       m_frame = 1'b0;

  always #5 clk = ~clk;

  seq_bit_serializer #(.DATA_W(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_m), .ser_bit(ser_m), .bit_valid(bv_m),
    .frame_start(fs_m), .busy(busy_m)
  );

  seq_bit_serializer #(.DATA_W(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_l), .ser_bit(ser_l), .bit_valid(bv_l),
    .frame_start(fs_l), .busy(busy_l)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_cur = 1'b0;
    m_pos = 0;
    m_hold.delete();
    m_ready = 1'b0;
    m_frame = 1'b0;
  endtask

  // One clock edge of the reference: retire the displayed bit, then refill from hold or input.
  task automatic model_edge(input logic v, input logic [7:0] d);
    logic acc, used;
    acc = v && m_ready;
    used = 1'b0;
    m_frame = 1'b0;
    if (m_cur) begin
      m_pos++;
      if (m_pos == 8) m_cur = 1'b0;
    end
    if (!m_cur) begin
      if (m_hold.size() > 0) begin
        m_word = m_hold.pop_front(); m_cur = 1'b1; m_pos = 0; m_frame = 1'b1;
      end else if (acc) begin
        m_word = d; m_cur = 1'b1; m_pos = 0; m_frame = 1'b1; used = 1'b1;
      end
    end
    if (acc && !used) m_hold.push_back(d);
    m_ready = (m_hold.size() == 0) || (m_cur && m_pos == 7);
  endtask

  task automatic check_all(input string tag);
    logic exp_m, exp_l, exp_busy;
    exp_m    = m_cur ? m_word[7 - m_pos] : 1'b0;
    exp_l    = m_cur ? m_word[m_pos] : 1'b0;
    exp_busy = m_cur || (m_hold.size() > 0);
    chk({tag, ".ser_msb"}, ser_m, exp_m);
    chk({tag, ".ser_lsb"}, ser_l, exp_l);
    chk({tag, ".bit_valid"}, bv_m, m_cur);
    chk({tag, ".bit_valid_lsb"}, bv_l, m_cur);
    chk({tag, ".frame_start"}, fs_m, m_frame);
    chk({tag, ".frame_start_lsb"}, fs_l, m_frame);
    chk({tag, ".in_ready"}, rdy_m, m_ready);
    chk({tag, ".in_ready_lsb"}, rdy_l, m_ready);
    chk({tag, ".busy"}, busy_m, exp_busy);
    chk({tag, ".busy_lsb"}, busy_l, exp_busy);
  endtask

  task automatic step(input string tag, input logic v, input logic [7:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    model_edge(v, d);
    #1;
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [15:0] stream;

  initial begin
    #2;
    model_reset();
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step("ready_rise", 1'b0, 8'h00);

    // MSB-first 8'hD0 (LSB instance sees the same word reversed); explicit stream check too.
    stream = '0;
    step("d0_accept", 1'b1, 8'hD0);
    stream[15] = ser_m;
    for (int i = 1; i < 8; i++) begin
      step("d0_shift", 1'b0, 8'h00);
      stream[15-i] = ser_m;
    end
    chk("d0_pattern", (stream[15:8] == 8'hD0), 1'b1);
    step("d0_idle", 1'b0, 8'h00);

    // LSB-first 8'h0B -> 1,1,0,1,0,0,0,0 on the LSB instance.
    step("0b_accept", 1'b1, 8'h0B);
    stream[15] = ser_l;
    for (int i = 1; i < 8; i++) begin
      step("0b_shift", 1'b0, 8'h00);
      stream[15-i] = ser_l;
    end
    chk("0b_pattern", (stream[15:8] == 8'hD0), 1'b1);
    step("0b_idle", 1'b0, 8'h00);

    // Back-to-back AA, 55 with valid held.
    step("aa_accept", 1'b1, 8'hAA);
    step("55_hold", 1'b1, 8'h55);
    for (int i = 0; i < 16; i++) step("b2b", 1'b0, 8'h00);

    // Third word held off until word 1's last bit.
    step("w1", 1'b1, 8'h11);
    step("w2", 1'b1, 8'h22);
    for (int i = 0; i < 8; i++) step("w3_pending", 1'b1, 8'h33);
    for (int i = 0; i < 18; i++) step("w3_drain", 1'b0, 8'h00);

    // Accept exactly on the last-bit edge: 0F then F0 gapless.
    step("0f_accept", 1'b1, 8'h0F);
    stream[15] = ser_m;
    for (int i = 1; i < 8; i++) begin
      step("0f_shift", 1'b0, 8'h00);
      stream[15-i] = ser_m;
    end
    for (int i = 0; i < 8; i++) begin
      step("f0_stream", (i == 0), 8'hF0);
      stream[7-i] = ser_m;
    end
    chk("gapless_pattern", (stream == 16'h0FF0), 1'b1);
    step("f0_idle", 1'b0, 8'h00);

    // Reset mid-word with a word held.
    step("ff_accept", 1'b1, 8'hFF);
    step("ff_hold", 1'b1, 8'hC3);
    step("ff_bit2", 1'b0, 8'h00);
    step("ff_bit3", 1'b0, 8'h00);
    async_reset("midword_reset");
    step("post_reset_ready", 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) step("post_reset_quiet", 1'b0, 8'h00);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 149) == 0) async_reset("rand_reset");
      step("rand", ($urandom_range(0, 2) != 0), 8'($urandom));
    end
    for (int i = 0; i < 20; i++) step("rand_drain", 1'b0, 8'h00);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
